ltc2656_update_scheduler: RTL and testbench
===========================================

Name: ltc2656_update_scheduler

Overview:
Controller that owns the SPI/LDAC pins of the LTC2656 octal DAC and sequences its updates. Eight per-channel requesters post new 16-bit codes at any time. The block stores each code in a shadow register and schedules "write input register" frames round-robin over pending channels. After the last pending frame it issues one LDAC pulse, so all updated outputs change together. It sits between the application logic and the DAC pins, or the DAC sim model in benches.

Parameters:
CLK_DIV, 4, sck half-period in clk cycles; must be at least 2.
CSLD_HIGH_CYCLES, 4, minimum csld high time between frames, in clk cycles.
LDAC_CYCLES, 4, ldac low pulse width, in clk cycles.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
upd_valid  in  8  per-channel update strobe; bit i is channel i (A=0 … H=7)
upd_value  in  128  per-channel codes; channel i at [16i+15:16i]
sck  out  1  SPI clock to DAC
sdi  out  1  SPI data to DAC, MSB first
csld  out  1  chip-select/load, active low during a frame
ldac  out  1  async DAC update, active low pulse
busy  out  1  high whenever state is not IDLE
pending  out  8  per-channel "code not yet sent" flags

Behaviour:
- Reset is asynchronous. While resetn=0: csld=1, sck=0, sdi=0, ldac=1, busy=0, pending=0, shadows=0, RR pointer=0, state=IDLE.
- Capture, every cycle, any state:
  - upd_valid[i]=1 writes shadow[i]<=value and sets pending[i].
  - A newer value overwrites an unsent older one; only the latest code is sent.
- States: IDLE, LOAD, SHIFT, CS_HIGH, LDAC.
- IDLE: pins at idle levels. If any pending → LOAD.
- LOAD (1 cycle):
  - Select the first pending channel at or after the RR pointer, wrapping 7→0.
  - shift <= {4'b0000, ch[3:0], shadow[ch]}.
  - Clear pending[ch] unless upd_valid[ch] is high the same cycle; in that case the flag stays set and the new value is sent in a later frame.
  - RR pointer <= ch+1 (mod 8). csld<=0, sdi<=bit23.
  - → SHIFT.
- SHIFT: 24 sck periods.
  - Each period: sck low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - sdi changes only on the sck falling edge, so it is stable for ≥CLK_DIV cycles before each rising edge.
  - After the 24th high phase: sck<=0, csld<=1 → CS_HIGH.
  - Frame length: 1 + 48·CLK_DIV cycles.
  - Updates to the in-flight channel do not disturb the shift register.
- CS_HIGH: hold csld=1 for CSLD_HIGH_CYCLES. Then:
  - if any pending → LOAD (no LDAC between frames);
  - else → LDAC.
- LDAC: ldac=0 for LDAC_CYCLES, then ldac=1 → IDLE.
  - Requests arriving during LDAC are captured and are served from IDLE on the next cycle.
- Fairness: with all 8 channels continuously pending, each channel gets one frame per 8 frames.
- Reset mid-frame: pins return to idle immediately and the partial frame is abandoned. Benches reset the DAC model in the same cycle.

Optional Feature:
Macro LTC2656_PWRDN_EN.
- Defined:
  - Adds input pwrdn_req (1 bit, pulse). A pulse sets an internal pwrdn_pending flag.
  - At the next LOAD decision, pwrdn_pending has priority over channel frames. The block sends 24'h5F0000 (cmd 0101, channel 1111) and clears the flag.
  - If no channel is pending after that frame, CS_HIGH → IDLE with no LDAC pulse, because LDAC would re-power the channels.
  - Channel pending flags are preserved across the power-down frame.
  - From IDLE, pwrdn_pending also triggers → LOAD.
- Undefined: no port, command 0101 is never issued, and the behaviour is exactly as above.

Test Plan:
- Single update:
  - Stimulus: upd_valid=8'h04, ch2=16'h1234.
  - Response: one frame 24'h021234 (model spi_dataword_out), then ldac low 4 cycles; model inp_c=dac_c=16'h1234; busy returns 0.
- Burst:
  - Stimulus: all 8 valid in one cycle, ch i=16'h1000+i.
  - Response: frames in order ch0..ch7, each CSLD_HIGH_CYCLES apart, exactly one LDAC pulse after ch7; model outputs 1000..1007.
- Coalescing:
  - Stimulus: ch3=16'hAAAA then 16'hBBBB while blocked behind a ch0 frame.
  - Response: only 24'h03BBBB is sent for ch3.
- In-flight overwrite:
  - Stimulus: ch5=16'h0001 during ch5's own SHIFT.
  - Response: the current frame keeps its original code; a second frame 24'h050001 follows before LDAC.
- Reset mid-SHIFT:
  - Stimulus: resetn=0 at bit 10.
  - Response: csld=1, sck=0, ldac=1, pending=0 in the same cycle; after release, no frame is sent without a new request.
- LTC2656_PWRDN_EN:
  - Stimulus: pwrdn_req while ch1 is pending.
  - Response: 24'h5F0000 first (model powered=0), then the ch1 frame, then LDAC (model powered=8'hFF).

Source files
------------

// File: rtl/ltc2656_update_scheduler_if.sv
// Request-side and DAC-pin bundle for the LTC2656 update scheduler.
// pwrdn_req exists only when LTC2656_PWRDN_EN is defined.
interface ltc2656_update_scheduler_if;
   logic [7:0]   upd_valid;
   logic [127:0] upd_value;
`ifdef LTC2656_PWRDN_EN
   logic         pwrdn_req;
`endif
   logic         sck;
   logic         sdi;
   logic         csld;
   logic         ldac;
   logic         busy;
   logic [7:0]   pending;

   modport master (
      input  upd_valid,
      input  upd_value,
`ifdef LTC2656_PWRDN_EN
      input  pwrdn_req,
`endif
      output sck,
      output sdi,
      output csld,
      output ldac,
      output busy,
      output pending
   );

   modport slave (
      output upd_valid,
      output upd_value,
`ifdef LTC2656_PWRDN_EN
      output pwrdn_req,
`endif
      input  sck,
      input  sdi,
      input  csld,
      input  ldac,
      input  busy,
      input  pending
   );
endinterface

// File: rtl/ltc2656_update_scheduler.sv
// Round-robin LTC2656 update scheduler: shadow codes, SPI frames, one LDAC per batch.
// Optional power-down command frame enabled by defining LTC2656_PWRDN_EN.
module ltc2656_update_scheduler #(
   parameter int CLK_DIV          = 4,
   parameter int CSLD_HIGH_CYCLES = 4,
   parameter int LDAC_CYCLES      = 4
) (
   input  logic                              clk,
   input  logic                              resetn,
   ltc2656_update_scheduler_if.master        bus
);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CS_HIGH, S_LDAC} state_t;

   localparam logic [15:0] PER_LAST  = 16'(2 * CLK_DIV - 1);
   localparam logic [15:0] SCK_HI    = 16'(CLK_DIV);
   localparam logic [15:0] CSH_LAST  = 16'(CSLD_HIGH_CYCLES - 1);
   localparam logic [15:0] LDAC_LAST = 16'(LDAC_CYCLES - 1);

   state_t      state, state_nx;
   logic [15:0] cnt;
   logic [4:0]  bit_cnt;
   logic [23:0] shift;
   logic [7:0]  pending;
   logic [15:0] shadow [8];
   logic [2:0]  rr;
   logic [2:0]  sel, idx;
   logic        sel_found;
   logic        take_ch;
   logic [7:0]  clr;
   logic        pd_pending;
   logic        frame_pd;
   logic        any_req;
   logic        period_end;

   assign period_end = (state == S_SHIFT) && (cnt == PER_LAST);
   assign any_req    = (|pending) || pd_pending;
   assign take_ch    = (state == S_LOAD) && !pd_pending;
   assign clr        = take_ch ? (8'b1 << sel) : 8'b0;

   // First pending channel at or after the round-robin pointer
   always_comb begin
      sel       = rr;
      sel_found = 1'b0;
      idx       = rr;
      for (int k = 0; k < 8; k++) begin
         idx = rr + 3'(k);
         if (!sel_found && pending[idx]) begin
            sel       = idx;
            sel_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (any_req) state_nx = S_LOAD;
         S_LOAD:    state_nx = S_SHIFT;
         S_SHIFT:   if (period_end && bit_cnt == 5'd23) state_nx = S_CS_HIGH;
         S_CS_HIGH: if (cnt == CSH_LAST) begin
                       if (any_req)       state_nx = S_LOAD;
                       else if (frame_pd) state_nx = S_IDLE;
                       else               state_nx = S_LDAC;
                    end
         S_LDAC:    if (cnt == LDAC_LAST) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      bus.csld    = 1'b1;
      bus.sck     = 1'b0;
      bus.sdi     = 1'b0;
      bus.ldac    = 1'b1;
      bus.busy    = (state != S_IDLE);
      bus.pending = pending;
      if (state == S_SHIFT) begin
         bus.csld = 1'b0;
         bus.sck  = (cnt >= SCK_HI);
         bus.sdi  = shift[23];
      end
      if (state == S_LDAC) bus.ldac = 1'b0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         bit_cnt <= '0;
      end else begin
         if (state_nx != state || state == S_IDLE || period_end) cnt <= '0;
         else                                                    cnt <= cnt + 16'd1;
         if (state == S_LOAD)  bit_cnt <= '0;
         else if (period_end)  bit_cnt <= bit_cnt + 5'd1;
      end
   end

   // Shift register is pure data; it is only observed while in SHIFT
   always_ff @(posedge clk) begin
      if (state == S_LOAD) begin
         if (pd_pending) shift <= 24'h5F0000;
         else            shift <= {5'b00000, sel, shadow[sel]};
      end else if (period_end) begin
         shift <= {shift[22:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pending <= '0;
         rr      <= '0;
         for (int i = 0; i < 8; i++) shadow[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++)
            if (bus.upd_valid[i]) shadow[i] <= bus.upd_value[16*i +: 16];
         pending <= (pending & ~clr) | bus.upd_valid;
         if (take_ch) rr <= sel + 3'd1;
      end
   end

`ifdef LTC2656_PWRDN_EN
   // Power-down wins the LOAD slot; a batch ending in it must not pulse LDAC
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pd_pending <= 1'b0;
         frame_pd   <= 1'b0;
      end else begin
         pd_pending <= bus.pwrdn_req || (pd_pending && state != S_LOAD);
         if (state == S_LOAD) frame_pd <= pd_pending;
      end
   end
`else
   assign pd_pending = 1'b0;
   assign frame_pd   = 1'b0;
`endif
endmodule

// File: tb/tb_ltc2656_update_scheduler.sv
// Scoreboard bench for ltc2656_update_scheduler with a behavioural LTC2656 pin model.
module tb_ltc2656_update_scheduler;
   localparam int          CLK_DIV    = 4;
   localparam int          CSH        = 4;
   localparam int          LDW        = 4;
   localparam logic [31:0] LDAC_TOKEN = 32'h0100_0000;
   localparam logic [31:0] NONE_TOKEN = 32'hEEEE_EEEE;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   ltc2656_update_scheduler_if bus ();

   ltc2656_update_scheduler #(
      .CLK_DIV(CLK_DIV), .CSLD_HIGH_CYCLES(CSH), .LDAC_CYCLES(LDW)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q [$];
   int          ev_cnt  = 0;
   int          mon_bits = 0;
   logic [15:0] inp [8];
   logic [15:0] dac [8];
   logic [7:0]  powered = 8'hFF;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pin monitor + DAC model: decodes frames and LDAC pulses, scores them against exp_q
   initial begin : monitor
      logic [23:0] word;
      logic        p_sck, p_csld, p_ldac, p_sdi;
      int          lo_cnt, ldac_w, gap;
      logic [31:0] e;
      word = '0; p_sck = 0; p_csld = 1; p_ldac = 1; p_sdi = 0;
      lo_cnt = 0; ldac_w = 0; gap = 100;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            mon_bits = 0; lo_cnt = 0; ldac_w = 0; gap = 100; powered = 8'hFF;
            for (int i = 0; i < 8; i++) begin inp[i] = '0; dac[i] = '0; end
         end else begin
            if (!bus.csld && p_csld) begin
               chk("csld_gap_ok", 32'(gap >= CSH), 32'd1);
               mon_bits = 0; lo_cnt = 0;
            end
            if (bus.csld) gap++;
            if (!bus.csld) lo_cnt++;
            if (bus.sck && !p_sck && !bus.csld) begin
               chk("sdi_setup", 32'(bus.sdi), 32'(p_sdi));
               word = {word[22:0], bus.sdi};
               mon_bits++;
            end
            if (bus.csld && !p_csld) begin
               chk("frame_bits", 32'(mon_bits), 32'd24);
               chk("frame_len", 32'(lo_cnt), 32'(48 * CLK_DIV));
               e = (exp_q.size() > 0) ? exp_q.pop_front() : NONE_TOKEN;
               chk("frame", {8'h00, word}, e);
               if (word[23:20] == 4'h0 && word[19:16] < 4'd8) inp[word[18:16]] = word[15:0];
               if (word[23:16] == 8'h5F) powered = 8'h00;
               ev_cnt++;
               gap = 1;
            end
            if (!bus.ldac) ldac_w++;
            if (bus.ldac && !p_ldac) begin
               chk("ldac_width", 32'(ldac_w), 32'(LDW));
               e = (exp_q.size() > 0) ? exp_q.pop_front() : NONE_TOKEN;
               chk("ldac_evt", LDAC_TOKEN, e);
               for (int i = 0; i < 8; i++) dac[i] = inp[i];
               powered = 8'hFF;
               ldac_w = 0;
               ev_cnt++;
            end
         end
         p_sck = bus.sck; p_csld = bus.csld; p_ldac = bus.ldac; p_sdi = bus.sdi;
      end
   end

   task automatic upd(input int ch, input logic [15:0] v);
      @(negedge clk); #1;
      bus.upd_valid = 8'(1 << ch);
      bus.upd_value[16*ch +: 16] = v;
      @(negedge clk); #1;
      bus.upd_valid = 8'h00;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (n < budget && (exp_q.size() != 0 || bus.busy || bus.pending != 8'h00)) begin
         @(negedge clk); #1;
         n++;
      end
      chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_idle"}, {23'd0, bus.busy, bus.pending}, 32'd0);
   endtask

   task automatic wait_bits(input int nb, input int budget);
      int n = 0;
      while (n < budget && !(mon_bits >= nb && !bus.csld)) begin
         @(negedge clk); #1;
         n++;
      end
      if (n >= budget) chk("wait_bits_timeout", 32'(mon_bits), 32'(nb));
   endtask

   initial begin : stim
      int base;
      bus.upd_valid = '0;
      bus.upd_value = '0;
`ifdef LTC2656_PWRDN_EN
      bus.pwrdn_req = 1'b0;
`endif
      repeat (3) @(negedge clk);
      #1;
      chk("reset_pins", {27'd0, bus.csld, bus.sck, bus.sdi, bus.ldac, bus.busy}, 32'b10010);
      chk("reset_pending", 32'(bus.pending), 32'd0);
      @(negedge clk); #1;
      resetn = 1'b1;

      // Burst: all channels in one cycle, RR pointer starts at 0
      for (int i = 0; i < 8; i++) exp_q.push_back({8'h00, 4'h0, 4'(i), 16'h1000 + 16'(i)});
      exp_q.push_back(LDAC_TOKEN);
      @(negedge clk); #1;
      bus.upd_valid = 8'hFF;
      for (int i = 0; i < 8; i++) bus.upd_value[16*i +: 16] = 16'h1000 + 16'(i);
      @(negedge clk); #1;
      bus.upd_valid = 8'h00;
      wait_idle("burst", 6000);
      for (int i = 0; i < 8; i++) chk("burst_dac", 32'(dac[i]), 32'h1000 + 32'(i));

      // Single update
      exp_q.push_back(32'h0002_1234);
      exp_q.push_back(LDAC_TOKEN);
      upd(2, 16'h1234);
      chk("single_pending", 32'(bus.pending), 32'h04);
      wait_idle("single", 1000);
      chk("single_inp", 32'(inp[2]), 32'h1234);
      chk("single_dac", 32'(dac[2]), 32'h1234);

      // Coalescing behind a ch0 frame
      exp_q.push_back(32'h0000_5555);
      exp_q.push_back(32'h0003_BBBB);
      exp_q.push_back(LDAC_TOKEN);
      upd(0, 16'h5555);
      wait_bits(2, 400);
      upd(3, 16'hAAAA);
      upd(3, 16'hBBBB);
      chk("coalesce_pending", 32'(bus.pending), 32'h08);
      wait_idle("coalesce", 2000);
      chk("coalesce_dac", 32'(dac[3]), 32'hBBBB);

      // In-flight overwrite of the channel being shifted
      exp_q.push_back(32'h0005_7777);
      exp_q.push_back(32'h0005_0001);
      exp_q.push_back(LDAC_TOKEN);
      upd(5, 16'h7777);
      wait_bits(5, 400);
      upd(5, 16'h0001);
      wait_idle("overwrite", 2000);
      chk("overwrite_dac", 32'(dac[5]), 32'h0001);

`ifdef LTC2656_PWRDN_EN
      // Power-down first, then the pending channel, then LDAC re-powers
      exp_q.push_back(32'h005F_0000);
      exp_q.push_back(32'h0001_4321);
      exp_q.push_back(LDAC_TOKEN);
      base = ev_cnt;
      @(negedge clk); #1;
      bus.upd_valid = 8'h02;
      bus.upd_value[31:16] = 16'h4321;
      bus.pwrdn_req = 1'b1;
      @(negedge clk); #1;
      bus.upd_valid = 8'h00;
      bus.pwrdn_req = 1'b0;
      for (int n = 0; n < 600 && ev_cnt < base + 1; n++) begin @(negedge clk); #1; end
      chk("pd_powered_off", 32'(powered), 32'h00);
      wait_idle("pwrdn", 2000);
      chk("pd_powered_on", 32'(powered), 32'hFF);
      chk("pd_dac", 32'(dac[1]), 32'h4321);

      // Power-down alone ends without an LDAC pulse
      exp_q.push_back(32'h005F_0000);
      base = ev_cnt;
      @(negedge clk); #1;
      bus.pwrdn_req = 1'b1;
      @(negedge clk); #1;
      bus.pwrdn_req = 1'b0;
      wait_idle("pd_alone", 1000);
      repeat (20) @(negedge clk);
      #1;
      chk("pd_alone_events", 32'(ev_cnt - base), 32'd1);
      chk("pd_alone_powered", 32'(powered), 32'h00);
`endif

      // Reset in the middle of a frame
      exp_q.push_back(32'h0006_ABCD);
      upd(6, 16'hABCD);
      wait_bits(10, 400);
      resetn = 1'b0;
      #1;
      exp_q.delete();
      chk("rst_mid_pins", {27'd0, bus.csld, bus.sck, bus.sdi, bus.ldac, bus.busy}, 32'b10010);
      chk("rst_mid_pending", 32'(bus.pending), 32'd0);
      repeat (2) @(negedge clk);
      @(posedge clk); #2;
      resetn = 1'b1;
      base = ev_cnt;
      repeat (300) @(negedge clk);
      #1;
      chk("rst_no_frame", 32'(ev_cnt - base), 32'd0);
      chk("rst_idle", {23'd0, bus.busy, bus.pending}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
